// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - SPI mode-0 responder oversampled on sys_clk (optional SPI_SLAVE_UNDERRUN_EN)
// Pins are synchronised, edges detected on sys_clk; one holding register buffers the next tx word.
module spi_slave_responder #(
  parameter int                 DATA_W       = 8,
  parameter int                 SYNC_STAGES  = 2,
  parameter logic [DATA_W-1:0]  TX_IDLE_WORD = '0
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic              tx_underrun
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]   cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]   mosi_sync_q, mosi_sync_d;
  logic                     sclk_hist_q, sclk_hist_d;
  logic                     cs_hist_q, cs_hist_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0]        rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]        tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]        rx_data_q, rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     miso_q, miso_d;
  logic                     last_bit_q, last_bit_d;
  logic [DATA_W-1:0]        hold_q, hold_d;
  logic                     hold_full_q, hold_full_d;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic                     underrun_q, underrun_d;
`endif

  logic              sclk_s, cs_s, mosi_s;
  logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic              word_start;
  logic [DATA_W-1:0] rx_word;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign rx_word   = {rx_shift_q, mosi_s};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_hist_d = sclk_s;
    cs_hist_d   = cs_s;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    miso_d      = miso_q;
    last_bit_d  = last_bit_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    word_start  = 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
    underrun_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d    = ACTIVE;
          word_start = 1'b1;
        end
      end
      ACTIVE: begin
        // cs_n release wins over a coincident sclk edge, so no reload follows the last word
        if (cs_rise) begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          miso_d     = 1'b0;
          last_bit_d = 1'b0;
          rx_shift_d = '0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_word[DATA_W-2:0];
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            last_bit_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          if (last_bit_q) begin
            word_start = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], tx_shift_q[DATA_W-1]};
            miso_d     = tx_shift_d[DATA_W-1];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_start) begin
      last_bit_d = 1'b0;
      bit_cnt_d  = '0;
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = TX_IDLE_WORD;
`ifdef SPI_SLAVE_UNDERRUN_EN
        underrun_d = 1'b1;
`endif
      end
      miso_d = tx_shift_d[DATA_W-1];
    end

    // Fill only while empty, so it never collides with a consume of the same cycle
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      last_bit_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      last_bit_q  <= last_bit_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) underrun_q <= 1'b0;
    else        underrun_q <= underrun_d;
  end
  assign tx_underrun = underrun_q;
`endif

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = ~hold_full_q;

endmodule
